rtc_display_refresh: RTL

Frame-synchronous scheduler that refreshes the clock/date/timer/alarm values shown by the VGA display. Once per frame, at the start of vertical blanking, it issues a fixed sequence of register reads to the RTC bus controller and captures the results in staging registers. On success it commits all values to its outputs in one cycle, so the display never shows a torn time within a frame. It sits between the RTC bus controller and the VGA display module, and drives that module's ANO..SEGT and ALARMA inputs.

---
 rtl/rtc_display_refresh.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_display_refresh.sv
`default_nettype none
// ============================================================================
// Module   : rtc_display_refresh
// Purpose  : Once per video frame, at the start of vertical blanking, reads
//            the date/time, timer and status registers from the RTC bus
//            controller into staging registers, then publishes all of them
//            in a single cycle so the display never shows a torn time.
// Options  : REFRESH_TIMER_EN - when defined, the timer registers
//            (0x41..0x43) are read and HORAT/MINT/SEGT are driven; when
//            undefined, they are tied to 0x00.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_display_refresh #(
  parameter int V_ACTIVE = 480,
  parameter int TIMEOUT  = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] ADDRV,
  input  logic       BUS_BUSY,
  output logic       RD_REQ,
  output logic [7:0] RD_ADDR,
  input  logic       RD_ACK,
  input  logic [7:0] RD_DATA,
  output logic [7:0] ANO,
  output logic [7:0] MES,
  output logic [7:0] DIA,
  output logic [7:0] HORA,
  output logic [7:0] MIN,
  output logic [7:0] SEG,
  output logic [7:0] HORAT,
  output logic [7:0] MINT,
  output logic [7:0] SEGT,
  output logic       ALARMA,
  output logic       FRAME_OK,
  output logic [7:0] SKIP_CNT,
  output logic [7:0] ERR_CNT
);

`ifdef REFRESH_TIMER_EN
  localparam int c_NUM_READS = 10;
`else
  localparam int c_NUM_READS = 7;
`endif
  // STATUS is always the last read and feeds ALARMA directly, so it is not staged
  localparam int         c_NUM_STAGE = c_NUM_READS - 1;
  localparam logic [3:0] c_LAST_IDX  = 4'(c_NUM_READS - 1);
  localparam logic [7:0] c_TIMEOUT   = 8'(TIMEOUT);
  localparam logic [9:0] c_V_ACTIVE  = 10'(V_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_GAP    = 3'd2,
    S_COMMIT = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_idx;
  logic [3:0] w_idx_next;
  logic [7:0] r_wait;
  logic       r_blank_q;
  logic       w_blank;
  logic       w_trigger;
  logic       w_ack;
  logic       w_commit_load;
  logic       r_rd_req;
  logic [7:0] r_rd_addr;
  logic [7:0] r_stage [c_NUM_STAGE];
  logic [7:0] r_ano, r_mes, r_dia, r_hora, r_min, r_seg;
  logic       r_alarma;
  logic       r_frame_ok;
  logic [7:0] r_skip_cnt;
  logic [7:0] r_err_cnt;

  // Read schedule: index -> RTC register address (STATUS 0x00 falls to default)
  function automatic logic [7:0] f_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    f_addr = 8'h21;
      4'd1:    f_addr = 8'h22;
      4'd2:    f_addr = 8'h23;
      4'd3:    f_addr = 8'h24;
      4'd4:    f_addr = 8'h25;
      4'd5:    f_addr = 8'h26;
`ifdef REFRESH_TIMER_EN
      4'd6:    f_addr = 8'h41;
      4'd7:    f_addr = 8'h42;
      4'd8:    f_addr = 8'h43;
`endif
      default: f_addr = 8'h00;
    endcase
  endfunction

  assign w_blank       = (ADDRV >= c_V_ACTIVE);
  assign w_trigger     = w_blank && !r_blank_q;
  assign w_ack         = (r_state == S_REQ) && RD_ACK;
  // The final ack loads the outputs so they are already visible in the COMMIT cycle
  assign w_commit_load = w_ack && (r_idx == c_LAST_IDX);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state and read-index sequencing
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_trigger && !BUS_BUSY) begin
          w_state_next = S_REQ;
          w_idx_next   = 4'd0;
        end
      end
      S_REQ: begin
        if (RD_ACK) begin
          w_state_next = (r_idx == c_LAST_IDX) ? S_COMMIT : S_GAP;
        end else if ((r_wait + 8'd1) == c_TIMEOUT) begin
          w_state_next = S_ABORT;
        end
      end
      S_GAP: begin
        w_state_next = S_REQ;
        w_idx_next   = r_idx + 4'd1;
      end
      S_COMMIT, S_ABORT: begin
        w_state_next = S_IDLE;
        w_idx_next   = 4'd0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = 4'd0;
      end
    endcase
  end

  // Bus request, wait counter, staging, committed outputs and statistics
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_blank_q  <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= 8'h00;
      r_wait     <= 8'd0;
      for (int i = 0; i < c_NUM_STAGE; i++) r_stage[i] <= 8'h00;
      r_ano      <= 8'h00;
      r_mes      <= 8'h00;
      r_dia      <= 8'h00;
      r_hora     <= 8'h00;
      r_min      <= 8'h00;
      r_seg      <= 8'h00;
      r_alarma   <= 1'b0;
      r_frame_ok <= 1'b0;
      r_skip_cnt <= 8'd0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_blank_q <= w_blank;
      r_rd_req  <= (w_state_next == S_REQ);
      if (w_state_next == S_REQ) r_rd_addr <= f_addr(w_idx_next);
      // Counts only consecutive unacknowledged REQ cycles; zero everywhere else
      r_wait <= ((r_state == S_REQ) && !RD_ACK) ? r_wait + 8'd1 : 8'd0;
      for (int i = 0; i < c_NUM_STAGE; i++) begin
        if (w_ack && (r_idx == 4'(i))) r_stage[i] <= RD_DATA;
      end
      if (w_commit_load) begin
        r_seg    <= r_stage[0];
        r_min    <= r_stage[1];
        r_hora   <= r_stage[2];
        r_dia    <= r_stage[3];
        r_mes    <= r_stage[4];
        r_ano    <= r_stage[5];
        r_alarma <= RD_DATA[0];
      end
      r_frame_ok <= w_commit_load;
      if ((r_state == S_IDLE) && w_trigger && BUS_BUSY && (r_skip_cnt != 8'hFF))
        r_skip_cnt <= r_skip_cnt + 8'd1;
      if ((r_state == S_ABORT) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

`ifdef REFRESH_TIMER_EN
  logic [7:0] r_horat, r_mint, r_segt;

  // Timer values committed together with the date/time
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_segt  <= 8'h00;
      r_mint  <= 8'h00;
      r_horat <= 8'h00;
    end else if (w_commit_load) begin
      r_segt  <= r_stage[6];
      r_mint  <= r_stage[7];
      r_horat <= r_stage[8];
    end
  end

  assign HORAT = r_horat;
  assign MINT  = r_mint;
  assign SEGT  = r_segt;
`else
  assign HORAT = 8'h00;
  assign MINT  = 8'h00;
  assign SEGT  = 8'h00;
`endif

  assign RD_REQ   = r_rd_req;
  assign RD_ADDR  = r_rd_addr;
  assign ANO      = r_ano;
  assign MES      = r_mes;
  assign DIA      = r_dia;
  assign HORA     = r_hora;
  assign MIN      = r_min;
  assign SEG      = r_seg;
  assign ALARMA   = r_alarma;
  assign FRAME_OK = r_frame_ok;
  assign SKIP_CNT = r_skip_cnt;
  assign ERR_CNT  = r_err_cnt;

endmodule
`default_nettype wire
